// File: rtl/dbus_bridge.sv
// Data-side bridge for the mips core: decodes the data port into the external
// data memory window or an internal countdown timer with an interrupt output.
module dbus_bridge #(
    parameter logic [31:0] DM_BASE = 32'h0000_0000,
    parameter logic [31:0] DM_END  = 32'h0000_2FFF,
    parameter logic [31:0] TC_BASE = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    output logic [31:0] m_data_rdata,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_byteen,
    input  logic [31:0] dm_rdata,
    output logic        irq
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

    state_t      r_state;
    logic [3:0]  r_ctrl;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_irq_flag;

    logic        w_hit_dm;
    logic        w_hit_tc;
    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_wr_pre;
    logic        w_auto;
    logic [31:0] w_tc_rdata;

    // Offset compares wrap unsigned, so a zero base needs no separate lower bound.
    assign w_hit_dm  = (m_data_addr - DM_BASE) <= (DM_END - DM_BASE);
    assign w_hit_tc  = (m_data_addr - TC_BASE) <= 32'd11;
    assign w_wr      = w_hit_tc && (m_data_byteen == 4'b1111);
    assign w_wr_ctrl = w_wr && (m_data_addr[3:2] == 2'd0);
    assign w_wr_pre  = w_wr && (m_data_addr[3:2] == 2'd1);
    assign w_auto    = (r_ctrl[2:1] == 2'b01);

    assign dm_addr   = m_data_addr;
    assign dm_wdata  = m_data_wdata;
    assign dm_byteen = w_hit_dm ? m_data_byteen : 4'b0000;

    always_comb begin
        w_tc_rdata = 32'h0;
        case (m_data_addr[3:2])
            2'd0:    w_tc_rdata = {28'h0, r_ctrl};
            2'd1:    w_tc_rdata = r_preset;
            2'd2:    w_tc_rdata = r_count;
            default: w_tc_rdata = 32'h0;
        endcase
    end

    always_comb begin
        m_data_rdata = 32'h0;
        if (w_hit_dm)
            m_data_rdata = dm_rdata;
        else if (w_hit_tc)
            m_data_rdata = w_tc_rdata;
    end

    // The INT state itself drives the pulse; the sticky flag holds it afterwards in one-shot.
    assign irq = r_ctrl[3] & (r_irq_flag | (r_state == S_INT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_ctrl     <= 4'h0;
            r_preset   <= 32'h0;
            r_count    <= 32'h0;
            r_irq_flag <= 1'b0;
        end else begin
            if (w_wr_pre)
                r_preset <= m_data_wdata;
            if (w_wr_ctrl || w_wr_pre)
                r_irq_flag <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (r_ctrl[0])
                        r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_count <= r_preset;
                    r_state <= S_CNT;
                end
                S_CNT: begin
                    if (!r_ctrl[0]) begin
                        r_state <= S_IDLE;
                    end else if (r_count > 32'd1) begin
                        r_count <= r_count - 32'd1;
                    end else begin
                        r_count <= 32'h0;
                        r_state <= S_INT;
                    end
                end
                S_INT: begin
                    if (w_auto) begin
                        r_state <= S_LOAD;
                    end else begin
                        r_ctrl[0] <= 1'b0;
                        if (!(w_wr_ctrl || w_wr_pre))
                            r_irq_flag <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Placed last so a CPU write overrides the hardware EN clear on the same edge.
            if (w_wr_ctrl)
                r_ctrl <= m_data_wdata[3:0];
        end
    end

endmodule

// File: tb/tb_dbus_bridge.sv
// Bench for dbus_bridge: decode vector table plus timer sequences checked
// against a queue of expected COUNT values and irq pulse times.
module tb_dbus_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_data_rdata;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_byteen;
    logic [31:0] dm_rdata;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dbus_bridge dut (
        .clk          (clk),
        .reset        (reset),
        .m_data_addr  (m_data_addr),
        .m_data_wdata (m_data_wdata),
        .m_data_byteen(m_data_byteen),
        .m_data_rdata (m_data_rdata),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_byteen    (dm_byteen),
        .dm_rdata     (dm_rdata),
        .irq          (irq)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] dmr;
        logic [31:0] exp_rd;
        logic [3:0]  exp_be;
    } vec_t;

    localparam logic [31:0] A_CTRL = 32'h0000_7F00;
    localparam logic [31:0] A_PRE  = 32'h0000_7F04;
    localparam logic [31:0] A_CNT  = 32'h0000_7F08;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        m_data_addr   = a;
        m_data_wdata  = d;
        m_data_byteen = be;
        tick();
        m_data_byteen = 4'b0000;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
        m_data_addr   = a;
        m_data_byteen = 4'b0000;
        #1;
        chk(nm, m_data_rdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vt[11];
        logic [31:0] q[$];
        logic [31:0] e;

        vt[0]  = '{32'h0000_7F00, 32'h0,         4'h0, 32'h1111_1111, 32'h0,         4'h0};
        vt[1]  = '{32'h0000_7F04, 32'h0,         4'h0, 32'h1111_1111, 32'h0,         4'h0};
        vt[2]  = '{32'h0000_7F08, 32'h0,         4'h0, 32'h1111_1111, 32'h0,         4'h0};
        vt[3]  = '{32'h0000_1004, 32'h0000_A5A5, 4'h3, 32'h1122_3344, 32'h1122_3344, 4'h3};
        vt[4]  = '{32'h0000_4000, 32'hFFFF_FFFF, 4'hF, 32'h0000_0055, 32'h0,         4'h0};
        vt[5]  = '{32'h0000_0000, 32'h0,         4'h0, 32'h0000_0001, 32'h0000_0001, 4'h0};
        vt[6]  = '{32'h0000_2FFF, 32'h0,         4'h8, 32'h0000_0022, 32'h0000_0022, 4'h8};
        vt[7]  = '{32'h0000_3000, 32'h0,         4'hF, 32'h0000_0033, 32'h0,         4'h0};
        vt[8]  = '{32'h0000_7EFF, 32'h0,         4'h0, 32'h0000_0044, 32'h0,         4'h0};
        vt[9]  = '{32'h0000_7F0C, 32'h0,         4'h0, 32'h0000_0066, 32'h0,         4'h0};
        vt[10] = '{32'hFFFF_7F00, 32'h0,         4'h0, 32'h0000_0077, 32'h0,         4'h0};

        reset         = 1'b0;
        m_data_addr   = 32'h0000_0010;
        m_data_wdata  = 32'h0;
        m_data_byteen = 4'hF;
        dm_rdata      = 32'hDEAD_BEEF;
        #12;
        chk("irq_in_reset", {31'h0, irq}, 32'h0);
        chk("dm_byteen_in_reset", {28'h0, dm_byteen}, 32'hF);
        chk("rdata_in_reset", m_data_rdata, 32'hDEAD_BEEF);
        m_data_byteen = 4'h0;
        reset = 1'b1;
        tick();
        chk("irq_after_reset", {31'h0, irq}, 32'h0);

        // Combinational decode table
        foreach (vt[i]) begin
            @(negedge clk);
            m_data_addr   = vt[i].addr;
            m_data_wdata  = vt[i].wdata;
            m_data_byteen = vt[i].be;
            dm_rdata      = vt[i].dmr;
            #1;
            chk($sformatf("vec%0d_rdata", i), m_data_rdata, vt[i].exp_rd);
            chk($sformatf("vec%0d_dm_byteen", i), {28'h0, dm_byteen}, {28'h0, vt[i].exp_be});
            chk($sformatf("vec%0d_dm_addr", i), dm_addr, vt[i].addr);
            chk($sformatf("vec%0d_dm_wdata", i), dm_wdata, vt[i].wdata);
        end
        m_data_byteen = 4'h0;
        dm_rdata      = 32'hDEAD_BEEF;
        tick();

        // One-shot, PRESET=5, IM=1
        wr(A_PRE, 32'd5, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        rd(A_CTRL, 32'h9, "ctrl_readback");
        tick();
        tick();
        for (int k = 0; k < 5; k++) q.push_back(32'd5 - k);
        for (int k = 0; k < 5; k++) begin
            e = q.pop_front();
            rd(A_CNT, e, $sformatf("oneshot_count_edge%0d", k + 2));
            chk("oneshot_irq_low", {31'h0, irq}, 32'h0);
            tick();
        end
        chk("oneshot_irq_rise", {31'h0, irq}, 32'h1);
        tick();
        rd(A_CTRL, 32'h8, "oneshot_en_cleared");
        chk("oneshot_irq_held", {31'h0, irq}, 32'h1);
        tick();
        chk("oneshot_irq_sticky", {31'h0, irq}, 32'h1);
        wr(A_PRE, 32'h1234, 4'hF);
        chk("oneshot_irq_cleared", {31'h0, irq}, 32'h0);
        rd(A_CNT, 32'h0, "oneshot_count_zero");

        // Partial writes and COUNT writes are ignored
        wr(A_PRE, 32'hFF, 4'h1);
        rd(A_PRE, 32'h1234, "partial_preset");
        wr(A_CTRL, 32'h1, 4'h3);
        rd(A_CTRL, 32'h8, "partial_ctrl");
        wr(A_CNT, 32'hFFFF_FFFF, 4'hF);
        rd(A_CNT, 32'h0, "count_write_ignored");

        // IM=0: FSM completes but irq stays low
        wr(A_PRE, 32'd2, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("masked_irq_c%0d", k), {31'h0, irq}, 32'h0);
        end
        rd(A_CTRL, 32'h0, "masked_en_cleared");

        // Auto-reload, PRESET=3 then PRESET=1 written at edge 18
        wr(A_PRE, 32'd3, 4'hF);
        wr(A_CTRL, 32'hB, 4'hF);
        q.delete();
        q.push_back(32'd5);  q.push_back(32'd10); q.push_back(32'd15);
        q.push_back(32'd20); q.push_back(32'd23); q.push_back(32'd26);
        q.push_back(32'd29);
        for (int c = 1; c <= 30; c++) begin
            if (c == 18) begin
                m_data_addr   = A_PRE;
                m_data_wdata  = 32'd1;
                m_data_byteen = 4'hF;
            end
            tick();
            m_data_byteen = 4'h0;
            if (irq) begin
                if (q.size() == 0)
                    chk("auto_extra_pulse", c, 32'hFFFF_FFFF);
                else
                    chk("auto_pulse_cycle", c, q.pop_front());
            end
        end
        chk("auto_pulses_missing", q.size(), 32'd0);
        wr(A_CTRL, 32'h0, 4'hF);
        tick();

        // Asynchronous reset mid-count
        wr(A_PRE, 32'd10, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        for (int k = 0; k < 5; k++) tick();
        rd(A_CNT, 32'd7, "prereset_count");
        reset = 1'b0;
        #1;
        chk("reset_count", m_data_rdata, 32'h0);
        rd(A_CTRL, 32'h0, "reset_ctrl");
        rd(A_PRE, 32'h0, "reset_preset");
        chk("reset_irq", {31'h0, irq}, 32'h0);
        tick();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        rd(A_CNT, 32'h0, "post_reset_count");
        chk("post_reset_irq", {31'h0, irq}, 32'h0);

        // FSM restarts from IDLE: INT expected exactly at edge 4 for PRESET=2
        wr(A_PRE, 32'd2, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("restart_irq_low_e%0d", k), {31'h0, irq}, 32'h0);
        end
        tick();
        chk("restart_irq_e4", {31'h0, irq}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
